// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in the EXE stage.
// Produces one quotient bit per cycle. The divide takes 32 BUSY cycles plus one
// DONE cycle. Divide-by-zero skips the iterations and goes straight to DONE.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start       request a divide (sampled only in IDLE)
//   signed_div  1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend    rs operand; sampled with start
//   divisor     rt operand; sampled with start
//   cancel      abort an in-flight divide (flush/exception)
//   quotient    LO result, registered, held until next DONE/reset
//   remainder   HI result, registered, held until next DONE/reset
//   ready       one-cycle pulse while in DONE
//   stall_req   holds the pipeline while a divide is being issued or iterated
module div_unit #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] ZERO_QUO = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_div,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              cancel,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              ready,
    output logic              stall_req
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              sgnq_q, sgnq_d;
    logic              sgnr_q, sgnr_d;
    logic [DATA_W-1:0] quotient_q, quotient_d;
    logic [DATA_W-1:0] remainder_q, remainder_d;

    // One restoring step: shift {rem,quo} left, subtract if the shifted
    // remainder covers the divisor. The shifted remainder needs DATA_W+1 bits
    // because an unsigned divisor near 2^32 leaves a remainder near 2^32.
    logic [DATA_W:0]   rem_sh;
    logic              sub_ok;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quo_nx;

    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_W-1]};
        sub_ok = (rem_sh >= {1'b0, dvs_q});
        rem_nx = sub_ok ? DATA_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[DATA_W-1:0];
        quo_nx = {quo_q[DATA_W-2:0], sub_ok};
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sgnq_d      = sgnq_q;
        sgnr_d      = sgnr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                // cancel in the same cycle as start refuses the divide
                if (start && !cancel) begin
                    if (divisor != '0) begin
                        // 0x80000000 negates to itself and is read as 2^31
                        quo_d   = (signed_div && dividend[DATA_W-1]) ? -dividend : dividend;
                        dvs_d   = (signed_div && divisor[DATA_W-1])  ? -divisor  : divisor;
                        sgnq_d  = signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        sgnr_d  = signed_div & dividend[DATA_W-1];
                        rem_d   = '0;
                        count_d = '0;
                        state_d = BUSY;
                    end else begin
                        quotient_d  = ZERO_QUO;
                        remainder_d = dividend;
                        state_d     = DONE;
                    end
                end
            end
            BUSY: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_nx;
                    quo_d   = quo_nx;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(DATA_W - 1)) begin
                        // results are registered on the way into DONE so they
                        // are valid in the same cycle ready pulses
                        quotient_d  = sgnq_q ? -quo_nx : quo_nx;
                        remainder_d = sgnr_q ? -rem_nx : rem_nx;
                        state_d     = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sgnq_q      <= 1'b0;
            sgnr_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sgnq_q      <= sgnq_d;
            sgnr_q      <= sgnr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ready     = (state_q == DONE);
    // the issuing cycle stalls too, so the DIV stays in EXE while it starts
    assign stall_req = ((state_q == IDLE) && start) || (state_q == BUSY);

endmodule
